// File: rtl/seq_restoring_divider_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package seq_restoring_divider_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH = 4;

   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

   localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/seq_restoring_divider_sub_borrow.sv
// Combinational N-bit subtractor a - b with borrow out (set when a < b).
module seq_restoring_divider_sub_borrow
   import seq_restoring_divider_pkg::*;
#(
   parameter int N = DEFAULT_WIDTH + 1
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] diff,
   output logic         borrow_out
);

   assign {borrow_out, diff} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, start/ready
// handshake in, one-cycle done pulse with registered quotient/remainder out.
module seq_restoring_divider
   import seq_restoring_divider_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CNT_W = cnt_width(WIDTH);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [WIDTH-1:0] divisor_q, divisor_d;
   logic [WIDTH:0]   r_q, r_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;
   logic             borrow;
   logic             sub_ok;
   logic [WIDTH:0]   r_next;

   // Shreg holds the unconsumed dividend bits above the quotient bits built so far.
   assign shifted = {r_q[WIDTH-1:0], shreg_q[WIDTH-1]};

   seq_restoring_divider_sub_borrow #(.N(WIDTH + 1)) u_sub (
      .a          (shifted),
      .b          ({1'b0, divisor_q}),
      .diff       (diff),
      .borrow_out (borrow)
   );

   // A set top bit of r would make the true shifted value exceed any divisor.
   assign sub_ok = ~borrow | r_q[WIDTH];
   assign r_next = sub_ok ? diff : shifted;

   always_comb begin
      // NOTE: every _d defaults to its _q first, so no branch can leave a latch.
      state_d     = state_q;
      shreg_d     = shreg_q;
      divisor_d   = divisor_q;
      r_d         = r_q;
      cnt_d       = cnt_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               if (divisor != '0) begin
                  state_d   = CALC;
                  shreg_d   = dividend;
                  divisor_d = divisor;
                  r_d       = '0;
                  cnt_d     = '0;
               end else begin
                  state_d     = DONE;
                  quotient_d  = '1;
                  remainder_d = dividend;
                  dbz_d       = 1'b1;
               end
            end
         end
         CALC: begin
            r_d     = r_next;
            shreg_d = {shreg_q[WIDTH-2:0], sub_ok};
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d     = DONE;
               quotient_d  = shreg_d;
               remainder_d = r_next[WIDTH-1:0];
               dbz_d       = 1'b0;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: non-blocking updates so every flop samples the pre-edge values together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         shreg_q     <= '0;
         divisor_q   <= '0;
         r_q         <= '0;
         cnt_q       <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         divisor_q   <= divisor_d;
         r_q         <= r_d;
         cnt_q       <= cnt_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_q       <= dbz_d;
      end
   end

   assign ready       = (state_q == IDLE);
   assign done        = (state_q == DONE);
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Randomized self-checking bench for seq_restoring_divider against an arithmetic model.
module tb_seq_restoring_divider;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         ready;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   int n_tests = 0;
   int n_fail  = 0;

   seq_restoring_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .ready       (ready),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a request is taken whenever the model is idle; the
   // answer is plain / and %, published after W edges (or at once for /0).
   bit           m_ready = 1'b1;
   bit           m_done  = 1'b0;
   int           m_left  = 0;
   logic [W-1:0] m_q = '0, m_r = '0;
   bit           m_z = 1'b0;
   logic [W-1:0] p_q = '0, p_r = '0;
   bit           p_z = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ready = 1'b1; m_done = 1'b0; m_left = 0;
         m_q = '0; m_r = '0; m_z = 1'b0;
      end else if (m_done) begin
         m_done = 1'b0; m_ready = 1'b1;
      end else if (m_ready) begin
         if (start) begin
            m_ready = 1'b0;
            if (divisor == '0) begin
               p_q = '1; p_r = dividend; p_z = 1'b1;
               m_done = 1'b1; m_q = p_q; m_r = p_r; m_z = p_z;
            end else begin
               p_q = dividend / divisor; p_r = dividend % divisor; p_z = 1'b0;
               m_left = W;
            end
         end
      end else begin
         m_left--;
         if (m_left == 0) begin
            m_done = 1'b1; m_q = p_q; m_r = p_r; m_z = p_z;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         check("ready",       32'(ready),       32'(m_ready));
         check("done",        32'(done),        32'(m_done));
         check("quotient",    32'(quotient),    32'(m_q));
         check("remainder",   32'(remainder),   32'(m_r));
         check("div_by_zero", 32'(div_by_zero), 32'(m_z));
         if (done && ready) check("done_and_ready", 1, 0);
      end
   end

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit noise, input bit hold_start,
                         output int lat, output logic [W-1:0] q,
                         output logic [W-1:0] r, output logic z);
      int waitc = 0;
      while (!ready && waitc < 40) begin
         @(negedge clk);
         waitc++;
      end
      if (!ready) check("ready_timeout", 32'(ready), 1);
      start = 1'b1; dividend = a; divisor = b;
      @(negedge clk);
      lat = 0;
      if (hold_start) begin
         dividend = 1; divisor = 1;
      end else begin
         start = 1'b0;
      end
      while (!done && lat < 40) begin
         if (noise) begin
            start = 1'($urandom); dividend = W'($urandom); divisor = W'($urandom);
         end
         @(negedge clk);
         lat++;
      end
      if (!done) check("done_timeout", 32'(done), 1);
      q = quotient; r = remainder; z = div_by_zero;
      start = 1'b0;
   endtask

   int           lat;
   logic [W-1:0] q, r;
   logic         z;

   initial begin
      repeat (2) @(negedge clk);
      check("rst_ready", 32'(ready), 1);
      check("rst_done", 32'(done), 0);
      check("rst_quotient", 32'(quotient), 0);
      check("rst_remainder", 32'(remainder), 0);
      check("rst_dbz", 32'(div_by_zero), 0);
      rst_n = 1'b1;
      @(negedge clk);

      run_op(4'd13, 4'd3, 1'b0, 1'b0, lat, q, r, z);
      check("13/3 latency_edges", lat, W);
      check("13/3 q", 32'(q), 4);
      check("13/3 r", 32'(r), 1);
      check("13/3 dbz", 32'(z), 0);
      @(negedge clk);
      check("13/3 done_single", 32'(done), 0);

      run_op(4'd15, 4'd1, 1'b0, 1'b0, lat, q, r, z);
      check("15/1 q", 32'(q), 15);
      check("15/1 r", 32'(r), 0);
      run_op(4'd0, 4'd5, 1'b0, 1'b0, lat, q, r, z);
      check("0/5 q", 32'(q), 0);
      check("0/5 r", 32'(r), 0);

      run_op(4'd3, 4'd7, 1'b0, 1'b0, lat, q, r, z);
      check("3/7 q", 32'(q), 0);
      check("3/7 r", 32'(r), 3);

      run_op(4'd7, 4'd0, 1'b0, 1'b0, lat, q, r, z);
      check("7/0 latency_edges", lat, 0);
      check("7/0 q", 32'(q), 15);
      check("7/0 r", 32'(r), 7);
      check("7/0 dbz", 32'(z), 1);
      run_op(4'd9, 4'd2, 1'b0, 1'b0, lat, q, r, z);
      check("9/2 q", 32'(q), 4);
      check("9/2 r", 32'(r), 1);
      check("9/2 dbz", 32'(z), 0);

      run_op(4'd14, 4'd4, 1'b0, 1'b1, lat, q, r, z);
      check("14/4 held_start q", 32'(q), 3);
      check("14/4 held_start r", 32'(r), 2);
      @(negedge clk);
      check("14/4 done_single", 32'(done), 0);

      // Abandon an operation mid-calculation with a one-cycle reset pulse.
      while (!ready) @(negedge clk);
      start = 1'b1; dividend = 4'd14; divisor = 4'd4;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_ready", 32'(ready), 1);
      check("midrst_done", 32'(done), 0);
      check("midrst_quotient", 32'(quotient), 0);
      check("midrst_remainder", 32'(remainder), 0);
      check("midrst_dbz", 32'(div_by_zero), 0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (8) @(negedge clk);
      run_op(4'd14, 4'd4, 1'b0, 1'b0, lat, q, r, z);
      check("14/4 after_reset q", 32'(q), 3);
      check("14/4 after_reset r", 32'(r), 2);

      for (int i = 0; i < 80; i++) begin
         logic [W-1:0] a, b;
         a = W'($urandom);
         b = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom);
         run_op(a, b, 1'($urandom), 1'b0, lat, q, r, z);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion before %0t", $time);
      $fatal(1);
   end

endmodule
